// File: rtl/axi_pkg.sv
// Shared AXI read-side types and helpers: burst/response encodings, the R-beat packet layout,
// and the per-beat address step and request legality rules.
package axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  localparam int unsigned AXI_ID_W = 4;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         data;
    resp_e               resp;
    logic                last;
  } r_pkt_t;

  localparam int unsigned R_PKT_W = $bits(r_pkt_t);

  // Requests the engine answers with SLVERR on every beat instead of touching the backend.
  function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size,
                                   input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BurstRsvd) || (size > 3'd2) || ((burst == BurstWrap) && !wrap_len_ok);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input burst_e burst,
                                            input logic [2:0] size, input logic [7:0] len);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BurstIncr: next_addr = addr + step;
      BurstWrap: next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:   next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/r_out_queue.sv
// Two-entry synchronous FIFO for R beats; push and pop may coincide, including when full.
module r_out_queue #(
  parameter int unsigned Width = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-side slave engine: one AR at a time, one backend word read per beat, R beats
// returned through a 2-entry queue with credit-based issue so no beat is lost under stall.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_ce,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned PktW = ID_W + R_PKT_W - AXI_ID_W;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beats_left_q;
  logic [2:0]        size_q;
  burst_e            burst_q;
  logic              err_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic              pop;
  logic              issue;
  logic              last_issue;
  logic              err_push;
  logic              credit;
  logic [2:0]        occ;
  logic [1:0]        q_count;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic [PktW-1:0]   q_head;
  logic [PktW-1:0]   q_push_data;
  logic [PktW-1:0]   mem_pkt;
  logic [PktW-1:0]   err_pkt;
  logic [PktW-1:0]   head_pkt;
  logic [PktW-1:0]   out_pkt;

  assign q_count = {q_full, ~q_full & ~q_empty};
  assign occ     = {1'b0, q_count} + {2'b00, inflight_q};
  assign pop     = rvalid & rready;
  assign credit  = (occ - {2'b00, pop}) < 3'd2;

  assign issue      = (state_q == StIssue) & credit;
  assign last_issue = (beats_left_q == 8'd0);
  assign mem_ce     = issue & ~err_q;
  assign err_push   = issue & err_q;
  assign mem_addr   = addr_q[MEM_AW+1:2];

  assign mem_pkt = {id_q, mem_rdata, RespOkay, inflight_last_q};
  assign err_pkt = {id_q, 32'd0, RespSlverr, last_issue};

  // The returning read is presented straight from the backend when the queue is empty, and
  // only parked in the queue if it is not taken that cycle; this keeps AR-to-R at two cycles.
  assign rvalid      = ~q_empty | inflight_q;
  assign head_pkt    = q_empty ? mem_pkt : q_head;
  assign q_pop       = pop & ~q_empty;
  assign q_push      = err_push | (inflight_q & ~(q_empty & pop));
  assign q_push_data = err_push ? err_pkt : mem_pkt;

  assign out_pkt = rvalid ? head_pkt : '0;
  assign {rid, rdata, rresp, rlast} = out_pkt;

  r_out_queue #(
    .Width (PktW)
  ) u_r_out_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    unique case (state_q)
      StIdle: begin
        arready = 1'b1;
        if (arvalid) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue && last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && rlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      beats_left_q    <= '0;
      size_q          <= '0;
      burst_q         <= BurstFixed;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= mem_ce;
      inflight_last_q <= last_issue;
      if (state_q == StIdle && arvalid) begin
        id_q         <= arid;
        addr_q       <= araddr;
        len_q        <= arlen;
        beats_left_q <= arlen;
        size_q       <= arsize;
        burst_q      <= burst_e'(arburst);
        err_q        <= bad_req(arburst, arsize, arlen);
      end else if (issue) begin
        addr_q       <= next_addr(addr_q, burst_q, size_q, len_q);
        beats_left_q <= beats_left_q - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: table of directed bursts, randomized bursts
// against a burst-level reference model, and hand-written reset / back-to-back sequences.
module tb_axi_read_responder;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned MEM_AW = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   arid = '0;
  logic [31:0]       araddr = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;
  logic              mem_ce;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [38:0]       exp_q[$];
  logic [MEM_AW-1:0] ewa_q[$];

  axi_read_responder #(
    .ID_W   (ID_W),
    .MEM_AW (MEM_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .mem_ce    (mem_ce),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Backend: word n holds n, one cycle of read latency.
  always @(posedge clk) begin
    if (mem_ce) mem_rdata <= {18'd0, mem_addr};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected beats and backend word addresses for a burst, from the address rules directly.
  function automatic void build_model(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    longint unsigned step, bnd, base, a;
    logic            bad;
    logic [31:0]     a32;
    exp_q.delete();
    ewa_q.delete();
    bad = (burst == 2'b11) || (size > 3'd2) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    step = 64'd1 << size;
    bnd  = (64'(len) + 64'd1) * step;
    base = 64'(addr) - (64'(addr) % bnd);
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'b01)      a = (64'(addr) + 64'(i) * step) & 64'hFFFF_FFFF;
      else if (burst == 2'b10) a = base + ((64'(addr) - base + 64'(i) * step) % bnd);
      else                     a = 64'(addr);
      a32 = a[31:0];
      ewa_q.push_back(a32[15:2]);
      exp_q.push_back({id, bad ? 32'd0 : {18'd0, a32[15:2]}, bad ? 2'b10 : 2'b00,
                       (i == int'(len))});
    end
    if (bad) ewa_q.delete();
  endfunction

  function automatic logic rready_pat(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Sends one AR, consumes the whole burst and checks it against the model.
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rmode,
                          input string tag, output int n_beats, output int first_waddr,
                          output int first_resp);
    int          waited, cyc, k, n_ce, first_rv, last_cyc;
    int          ar_bad, addr_bad, stab_bad, occ_bad;
    logic        done, prev_stall;
    logic [38:0] pkt, prev_pkt;
    build_model(id, addr, len, size, burst);
    n_beats = 0; first_waddr = -1; first_resp = -1;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    waited = 0;
    @(negedge clk);
    while (!arready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " arready"}, arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    cyc = 0; k = 0; n_ce = 0; first_rv = -1; last_cyc = -1; done = 1'b0; prev_stall = 1'b0;
    ar_bad = 0; addr_bad = 0; stab_bad = 0; occ_bad = 0; prev_pkt = '0;
    while (!done && cyc < 400) begin
      rready = rready_pat(rmode, cyc);
      @(negedge clk);
      cyc++;
      pkt = {rid, rdata, rresp, rlast};
      if (arready) ar_bad++;
      if (mem_ce) begin
        if (n_ce == 0) first_waddr = int'(mem_addr);
        if (n_ce >= ewa_q.size() || mem_addr !== ewa_q[n_ce]) addr_bad++;
        n_ce++;
      end
      if (rvalid && first_rv < 0) first_rv = cyc;
      if (prev_stall && pkt !== prev_pkt) stab_bad++;
      if (rvalid && rready) begin
        if (k == 0) first_resp = int'(rresp);
        if (k < exp_q.size()) check($sformatf("%s beat%0d", tag, k), pkt, exp_q[k]);
        else check($sformatf("%s extra beat%0d", tag, k), 1, 0);
        k++;
        if (rlast) begin
          done = 1'b1;
          last_cyc = cyc;
        end
      end
      if (n_ce - k > 2) occ_bad++;
      prev_stall = rvalid && !rready;
      prev_pkt   = pkt;
      @(posedge clk); #1;
    end
    rready  = 1'b0;
    n_beats = k;
    check({tag, " rlast seen"}, done, 1);
    check({tag, " beat count"}, k, exp_q.size());
    check({tag, " first rvalid latency"}, first_rv, 2);
    check({tag, " mem_ce count"}, n_ce, ewa_q.size());
    check({tag, " mem_addr sequence errors"}, addr_bad, 0);
    check({tag, " arready during burst"}, ar_bad, 0);
    check({tag, " head stability errors"}, stab_bad, 0);
    check({tag, " occupancy overruns"}, occ_bad, 0);
    if (rmode == 0) check({tag, " last beat cycle"}, last_cyc, int'(len) + 2);
    @(negedge clk);
    check({tag, " arready after rlast"}, arready, 1);
    check({tag, " rvalid after rlast"}, rvalid, 0);
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          rmode;
    int          exp_beats;
    int          exp_w0;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          nb, w0, r0, got, c_last, c_ar;
    logic [3:0]  rids[$];

    //          id    addr           len   size  burst rmode beats w0       err
    vecs[0]  = '{4'd3, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 0, 4,  'h40,   1'b0};
    vecs[1]  = '{4'd4, 32'h0000_0018, 8'd3, 3'd2, 2'b10, 0, 4,  'h6,    1'b0};
    vecs[2]  = '{4'd7, 32'h0000_0200, 8'd7, 3'd2, 2'b01, 1, 8,  'h80,   1'b0};
    vecs[3]  = '{4'd9, 32'h0000_0040, 8'd2, 3'd2, 2'b11, 0, 3,  -1,     1'b1};
    vecs[4]  = '{4'd2, 32'h0000_0044, 8'd2, 3'd2, 2'b00, 0, 3,  'h11,   1'b0};
    vecs[5]  = '{4'd1, 32'h0000_0003, 8'd5, 3'd0, 2'b01, 1, 6,  'h0,    1'b0};
    vecs[6]  = '{4'd6, 32'h0000_0006, 8'd1, 3'd1, 2'b10, 0, 2,  'h1,    1'b0};
    vecs[7]  = '{4'd8, 32'h0000_0010, 8'd0, 3'd3, 2'b01, 0, 1,  -1,     1'b1};
    vecs[8]  = '{4'hA, 32'h0000_0020, 8'd2, 3'd2, 2'b10, 1, 3,  -1,     1'b1};
    vecs[9]  = '{4'hB, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, 0, 4,  'h3FFE, 1'b0};
    vecs[10] = '{4'hC, 32'h0000_0134, 8'd15, 3'd2, 2'b10, 2, 16, 'h4D,  1'b0};

    // Reset state, sampled in the first cycle after reset release.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset arready", arready, 1);
    check("reset rvalid", rvalid, 0);
    check("reset mem_ce", mem_ce, 0);
    check("reset rlast", rlast, 0);
    check("reset rid/rdata/rresp", {rid, rdata, rresp}, 0);

    foreach (vecs[i]) begin
      do_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
               vecs[i].rmode, $sformatf("vec%0d", i), nb, w0, r0);
      check($sformatf("vec%0d table beats", i), nb, vecs[i].exp_beats);
      check($sformatf("vec%0d table first word", i), w0, vecs[i].exp_w0);
      check($sformatf("vec%0d table resp", i), r0, vecs[i].exp_err ? 2 : 0);
    end

    for (int i = 0; i < 24; i++) begin
      logic [1:0] b;
      logic [7:0] l;
      b = 2'($urandom_range(0, 3));
      l = (b == 2'b10 && $urandom_range(0, 3) != 0) ? 8'((1 << $urandom_range(1, 4)) - 1)
                                                     : 8'($urandom_range(0, 15));
      do_burst(4'($urandom), $urandom, l, 3'($urandom_range(0, 3)), b, 2,
               $sformatf("rnd%0d", i), nb, w0, r0);
    end

    // Reset after two of eight beats: the rest of the burst must vanish.
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 4'd6; araddr = 32'h300; arlen = 8'd7; arsize = 3'd2;
    arburst = 2'b01; rready = 1'b1;
    @(negedge clk);
    check("rstmid arready", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (rvalid && rready) got++;
    end
    check("rstmid beats before reset", got, 2);
    @(posedge clk); #1 rst = 1'b1; rready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid rvalid", rvalid, 0);
    check("rstmid arready", arready, 1);
    check("rstmid mem_ce", mem_ce, 0);
    @(negedge clk);
    check("rstmid rvalid later", rvalid, 0);
    do_burst(4'd5, 32'h20, 8'd0, 3'd2, 2'b01, 0, "post-reset", nb, w0, r0);

    // Back-to-back ARs: the second is held until the cycle after the first rlast handshake.
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 4'd1; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2;
    arburst = 2'b01; rready = 1'b1;
    @(negedge clk);
    check("b2b first arready", arready, 1);
    @(posedge clk); #1 arid = 4'd2; araddr = 32'h44;
    c_last = -1; c_ar = -1;
    for (int c = 1; c <= 20 && c_ar < 0; c++) begin
      @(negedge clk);
      if (rvalid && rready) begin
        rids.push_back(rid);
        if (rlast && c_last < 0) c_last = c;
      end
      if (arready) c_ar = c;
    end
    check("b2b first rlast cycle", c_last, 2);
    check("b2b second ar accept cycle", c_ar, c_last + 1);
    @(posedge clk); #1 arvalid = 1'b0;
    for (int c = 0; c < 20 && rids.size() < 2; c++) begin
      @(negedge clk);
      if (rvalid && rready) rids.push_back(rid);
    end
    check("b2b beat count", rids.size(), 2);
    if (rids.size() == 2) begin
      check("b2b rid order first", rids[0], 1);
      check("b2b rid order second", rids[1], 2);
    end
    rready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
